// File: rtl/chip8_video_pkg.sv
// Shared geometry, default panel timing and helpers for the CHIP-8 LCD scan-out.
package chip8_video_pkg;

    // Framebuffer geometry
    localparam int FB_W    = 64;
    localparam int FB_H    = 32;
    localparam int FB_AW   = 11;

    // Integer scale factors and the resulting window size
    localparam int SCALE_X = 7;
    localparam int SCALE_Y = 8;
    localparam int WIN_W   = FB_W * SCALE_X;   // 448
    localparam int WIN_H   = FB_H * SCALE_Y;   // 256

    // Counter widths for the scaler
    localparam int XC_W    = $clog2(FB_W);
    localparam int YC_W    = $clog2(FB_H);
    localparam int XS_W    = $clog2(SCALE_X);
    localparam int YS_W    = $clog2(SCALE_Y);

    // Default panel timing (480x272 class panel)
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 43;
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 12;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_WIN_X0   = 16;
    localparam int DEF_WIN_Y0   = 8;

    localparam logic [15:0] DEF_FG_RGB     = 16'h07E0;
    localparam logic [15:0] DEF_BG_RGB     = 16'h0000;
    localparam logic [15:0] DEF_BORDER_RGB = 16'h0000;

    // Raw (active-high) sideband carried alongside the pixel through the pipe
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic fs;
    } sideband_t;

    // Framebuffer read address for a cell
    function automatic logic [FB_AW-1:0] cell_addr(input logic [YC_W-1:0] ycell,
                                                   input logic [XC_W-1:0] xcell);
        return {ycell, xcell};
    endfunction

    // Colour select in priority order: blanking interval, border, blank, cell
    function automatic logic [15:0] pick_rgb(input logic        de,
                                             input logic        win,
                                             input logic        blank,
                                             input logic        data,
                                             input logic [15:0] fg,
                                             input logic [15:0] bg,
                                             input logic [15:0] border);
        logic [15:0] rgb;
        if (!de) begin
            rgb = 16'h0000;
        end else if (!win) begin
            rgb = border;
        end else if (blank) begin
            rgb = bg;
        end else if (data) begin
            rgb = fg;
        end else begin
            rgb = bg;
        end
        return rgb;
    endfunction

endpackage

// File: rtl/chip8_lcd_scanout_if.sv
// Framebuffer read port between the scan-out (master) and the framebuffer RAM (slave).
interface chip8_lcd_scanout_if import chip8_video_pkg::*; ();

    logic [FB_AW-1:0] fb_addr;   // read address, registered by the master
    logic             fb_data;   // cell value, one clock after fb_addr

    modport master (output fb_addr, input  fb_data);
    modport slave  (input  fb_addr, output fb_data);

endinterface

// File: rtl/lcd_raster_counter.sv
// Panel raster counters with stage-0 raw sync/DE decode and frame-start pulse.
module lcd_raster_counter import chip8_video_pkg::*; #(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_hc,
    output logic [VW-1:0] o_vc,
    output logic          o_line_end,
    output logic          o_hsync_raw,
    output logic          o_vsync_raw,
    output logic          o_de_raw,
    output logic          o_frame_pulse
);

    localparam logic [HW-1:0] L_H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] L_V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] L_H_SYNC  = HW'(H_SYNC);
    localparam logic [VW-1:0] L_V_SYNC  = VW'(V_SYNC);
    localparam logic [HW-1:0] L_H_DE0   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] L_H_DE1   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] L_V_DE0   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] L_V_DE1   = VW'(V_SYNC + V_BP + V_ACTIVE);

    logic [HW-1:0] r_hc;
    logic [VW-1:0] r_vc;
    logic          w_line_end;

    assign w_line_end = (r_hc == L_H_LAST);

    // Horizontal/vertical position: hc wraps each line, vc steps on hc wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_line_end) begin
            r_hc <= '0;
            if (r_vc == L_V_LAST) begin
                r_vc <= '0;
            end else begin
                r_vc <= r_vc + VW'(1);
            end
        end else begin
            r_hc <= r_hc + HW'(1);
        end
    end

    assign o_hc          = r_hc;
    assign o_vc          = r_vc;
    assign o_line_end    = w_line_end;
    assign o_hsync_raw   = (r_hc < L_H_SYNC);
    assign o_vsync_raw   = (r_vc < L_V_SYNC);
    assign o_de_raw      = (r_hc >= L_H_DE0) && (r_hc < L_H_DE1) &&
                           (r_vc >= L_V_DE0) && (r_vc < L_V_DE1);
    assign o_frame_pulse = (r_hc == '0) && (r_vc == '0);

endmodule

// File: rtl/chip8_lcd_scanout.sv
// CHIP-8 64x32 framebuffer to RGB565 LCD scan-out with 7x8 cell scaling.
// Three-stage pipe: counters -> fb_addr + sideband -> fb_data + sideband -> pins.
module chip8_lcd_scanout import chip8_video_pkg::*; #(
    parameter int          H_SYNC     = DEF_H_SYNC,
    parameter int          H_BP       = DEF_H_BP,
    parameter int          H_ACTIVE   = DEF_H_ACTIVE,
    parameter int          H_TOTAL    = DEF_H_TOTAL,
    parameter int          V_SYNC     = DEF_V_SYNC,
    parameter int          V_BP       = DEF_V_BP,
    parameter int          V_ACTIVE   = DEF_V_ACTIVE,
    parameter int          V_TOTAL    = DEF_V_TOTAL,
    parameter int          WIN_X0     = DEF_WIN_X0,
    parameter int          WIN_Y0     = DEF_WIN_Y0,
    parameter logic [15:0] FG_RGB     = DEF_FG_RGB,
    parameter logic [15:0] BG_RGB     = DEF_BG_RGB,
    parameter logic [15:0] BORDER_RGB = DEF_BORDER_RGB
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       blank,
    chip8_lcd_scanout_if.master        fb,
    output logic                       lcd_hsync,
    output logic                       lcd_vsync,
    output logic                       lcd_de,
    output logic [4:0]                 lcd_r,
    output logic [5:0]                 lcd_g,
    output logic [4:0]                 lcd_b,
    output logic                       frame_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // Window edges expressed directly in raster-counter coordinates
    localparam logic [HW-1:0] L_WX0 = HW'(H_SYNC + H_BP + WIN_X0);
    localparam logic [HW-1:0] L_WX1 = HW'(H_SYNC + H_BP + WIN_X0 + WIN_W);
    localparam logic [VW-1:0] L_WY0 = VW'(V_SYNC + V_BP + WIN_Y0);
    localparam logic [VW-1:0] L_WY1 = VW'(V_SYNC + V_BP + WIN_Y0 + WIN_H);

    localparam logic [XS_W-1:0] L_XSUB_LAST = XS_W'(SCALE_X - 1);
    localparam logic [YS_W-1:0] L_YSUB_LAST = YS_W'(SCALE_Y - 1);

    logic [HW-1:0]    w_hc;
    logic [VW-1:0]    w_vc;
    logic             w_line_end;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_de_raw;
    logic             w_fs_raw;
    logic             w_win;
    sideband_t        w_sb0;

    logic [XS_W-1:0]  r_xsub;
    logic [XC_W-1:0]  r_xcell;
    logic [YS_W-1:0]  r_ysub;
    logic [YC_W-1:0]  r_ycell;
    logic             r_line_win;

    logic [FB_AW-1:0] r_fb_addr;
    sideband_t        r_sb1;
    sideband_t        r_sb2;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [15:0]      r_rgb;
    logic             r_fs;

    lcd_raster_counter #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_raster (
        .i_clk         (sys_clk),
        .i_rst_n       (sys_rst_n),
        .o_hc          (w_hc),
        .o_vc          (w_vc),
        .o_line_end    (w_line_end),
        .o_hsync_raw   (w_hs_raw),
        .o_vsync_raw   (w_vs_raw),
        .o_de_raw      (w_de_raw),
        .o_frame_pulse (w_fs_raw)
    );

    assign w_win = w_de_raw &&
                   (w_hc >= L_WX0) && (w_hc < L_WX1) &&
                   (w_vc >= L_WY0) && (w_vc < L_WY1);

    assign w_sb0 = {w_hs_raw, w_vs_raw, w_de_raw, w_win, w_fs_raw};

    // Horizontal scaler: 7 window clocks per cell, restarted every line
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xsub  <= '0;
            r_xcell <= '0;
        end else if (w_line_end) begin
            r_xsub  <= '0;
            r_xcell <= '0;
        end else if (w_win) begin
            if (r_xsub == L_XSUB_LAST) begin
                r_xsub  <= '0;
                r_xcell <= r_xcell + XC_W'(1);
            end else begin
                r_xsub  <= r_xsub + XS_W'(1);
            end
        end else begin
            r_xsub  <= r_xsub;
            r_xcell <= r_xcell;
        end
    end

    // Remembers whether the current line touched the window
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_line_win <= 1'b0;
        end else if (w_line_end) begin
            r_line_win <= 1'b0;
        end else if (w_win) begin
            r_line_win <= 1'b1;
        end else begin
            r_line_win <= r_line_win;
        end
    end

    // Vertical scaler: 8 window lines per cell, restarted on line 0
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ysub  <= '0;
            r_ycell <= '0;
        end else if (w_vc == '0) begin
            r_ysub  <= '0;
            r_ycell <= '0;
        end else if (w_line_end && r_line_win) begin
            if (r_ysub == L_YSUB_LAST) begin
                r_ysub  <= '0;
                r_ycell <= r_ycell + YC_W'(1);
            end else begin
                r_ysub  <= r_ysub + YS_W'(1);
            end
        end else begin
            r_ysub  <= r_ysub;
            r_ycell <= r_ycell;
        end
    end

    // Stage 1: framebuffer address (held outside the window) plus sideband
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fb_addr <= '0;
            r_sb1     <= '0;
        end else begin
            r_sb1 <= w_sb0;
            if (w_win) begin
                r_fb_addr <= cell_addr(r_ycell, r_xcell);
            end else begin
                r_fb_addr <= r_fb_addr;
            end
        end
    end

    // Stage 2: sideband waits for the framebuffer read data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sb2 <= '0;
        end else begin
            r_sb2 <= r_sb1;
        end
    end

    // Stage 3: registered pins, syncs inverted to active-low
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= 16'h0000;
            r_fs    <= 1'b0;
        end else begin
            r_hsync <= ~r_sb2.hs;
            r_vsync <= ~r_sb2.vs;
            r_de    <= r_sb2.de;
            r_rgb   <= pick_rgb(r_sb2.de, r_sb2.win, blank, fb.fb_data,
                                FG_RGB, BG_RGB, BORDER_RGB);
            r_fs    <= r_sb2.fs;
        end
    end

    assign fb.fb_addr  = r_fb_addr;
    assign lcd_hsync   = r_hsync;
    assign lcd_vsync   = r_vsync;
    assign lcd_de      = r_de;
    assign lcd_r       = r_rgb[15:11];
    assign lcd_g       = r_rgb[10:5];
    assign lcd_b       = r_rgb[4:0];
    assign frame_start = r_fs;

endmodule

// File: tb/tb_chip8_lcd_scanout.sv
// Directed bench for chip8_lcd_scanout at default panel timing.
module tb_chip8_lcd_scanout;

    localparam int HT = 800;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       blank;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       lcd_de;
    logic [4:0] lcd_r;
    logic [5:0] lcd_g;
    logic [4:0] lcd_b;
    logic       frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fb_mode  = 1;   // 0: all clear, 1: only cell 65 set, 2: all set

    chip8_lcd_scanout_if u_fb ();

    chip8_lcd_scanout u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .blank       (blank),
        .fb          (u_fb),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_de      (lcd_de),
        .lcd_r       (lcd_r),
        .lcd_g       (lcd_g),
        .lcd_b       (lcd_b),
        .frame_start (frame_start)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Framebuffer RAM model: synchronous read, one clock of latency
    always @(posedge sys_clk) begin
        if (fb_mode == 2)
            u_fb.fb_data <= 1'b1;
        else if (fb_mode == 1)
            u_fb.fb_data <= (u_fb.fb_addr == 11'd65);
        else
            u_fb.fb_data <= 1'b0;
    end

    // Cycle index (edges after reset release) at which the pins show (vc,hc)
    function automatic int pk(input int v, input int h);
        return v * HT + h + 3;
    endfunction

    // Cycle index at which fb_addr reflects position (vc,hc)
    function automatic int ak(input int v, input int h);
        return v * HT + h + 1;
    endfunction

    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rgb();
        return {lcd_r, lcd_g, lcd_b};
    endfunction

    task automatic check_reset_pins(input string tag);
        check({tag, "_hsync"}, 32'(lcd_hsync), 32'd1);
        check({tag, "_vsync"}, 32'(lcd_vsync), 32'd1);
        check({tag, "_de"},    32'(lcd_de),    32'd0);
        check({tag, "_rgb"},   32'(rgb()),     32'h0);
        check({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        blank     = 1'b0;
        fb_mode   = 1;
        repeat (3) @(negedge sys_clk);
        check_reset_pins("rst");
        check("rst_addr", 32'(u_fb.fb_addr), 32'd0);

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;

        // Pins hold reset values for 3 clocks, then show (0,0)
        tick_to(1);  check_reset_pins("rel1");
        tick_to(2);  check_reset_pins("rel2");
        tick_to(3);
        check("p00_hsync", 32'(lcd_hsync),   32'd0);
        check("p00_vsync", 32'(lcd_vsync),   32'd0);
        check("p00_fs",    32'(frame_start), 32'd1);
        check("p00_de",    32'(lcd_de),      32'd0);
        tick_to(4);  check("p01_fs", 32'(frame_start), 32'd0);
        tick_to(6);  check("hs_last_low", 32'(lcd_hsync), 32'd0);
        tick_to(7);  check("hs_rise",     32'(lcd_hsync), 32'd1);
        tick_to(pk(1, 0));
        check("l1_fs",    32'(frame_start), 32'd0);
        check("l1_hsync", 32'(lcd_hsync),   32'd0);
        tick_to(pk(3, 799)); check("vs_last_low", 32'(lcd_vsync), 32'd0);
        tick_to(pk(4, 0));   check("vs_rise",     32'(lcd_vsync), 32'd1);

        // First DE on line 16 at hc 47; that pixel is border colour
        tick_to(pk(15, 47)); check("de_l15", 32'(lcd_de), 32'd0);
        tick_to(pk(16, 46)); check("de_h46", 32'(lcd_de), 32'd0);
        tick_to(pk(16, 47));
        check("de_first",  32'(lcd_de), 32'd1);
        check("de_border", 32'(rgb()),  32'h0);

        // Framebuffer address walk on the first window rows
        tick_to(ak(24, 69));  check("addr_0_end",  32'(u_fb.fb_addr), 32'd0);
        tick_to(ak(24, 70));  check("addr_1",      32'(u_fb.fb_addr), 32'd1);
        tick_to(ak(24, 510)); check("addr_63",     32'(u_fb.fb_addr), 32'd63);
        tick_to(ak(24, 600)); check("addr_hold",   32'(u_fb.fb_addr), 32'd63);
        tick_to(ak(25, 63));  check("addr_row0_2", 32'(u_fb.fb_addr), 32'd0);
        tick_to(pk(31, 73));
        check("pix_above_cell", 32'(rgb()),  32'h0);
        check("de_in_win",      32'(lcd_de), 32'd1);
        tick_to(ak(31, 80));  check("addr_row0_8", 32'(u_fb.fb_addr), 32'd2);
        tick_to(ak(32, 63));  check("addr_64",     32'(u_fb.fb_addr), 32'd64);
        tick_to(ak(32, 70));  check("addr_65",     32'(u_fb.fb_addr), 32'd65);

        // Cell (1,1) renders as a 7x8 block of foreground
        tick_to(pk(32, 69)); check("pix_left",   32'(rgb()), 32'h0);
        tick_to(pk(32, 70));
        check("pix_tl",    32'(rgb()),  32'h07E0);
        check("pix_tl_g",  32'(lcd_g),  32'h3F);
        check("pix_tl_de", 32'(lcd_de), 32'd1);
        tick_to(pk(32, 76)); check("pix_tr",     32'(rgb()), 32'h07E0);
        tick_to(pk(32, 77)); check("pix_right",  32'(rgb()), 32'h0);
        tick_to(ak(32, 510)); check("addr_127", 32'(u_fb.fb_addr), 32'd127);
        tick_to(pk(39, 73)); check("pix_bottom", 32'(rgb()), 32'h07E0);
        tick_to(pk(40, 73)); check("pix_below",  32'(rgb()), 32'h0);

        // All cells set: window edges against the border
        tick_to(pk(40, 200));
        fb_mode = 2;
        tick_to(pk(41, 62));
        check("win_l_border", 32'(rgb()),  32'h0);
        check("win_l_de",     32'(lcd_de), 32'd1);
        tick_to(pk(41, 63));  check("win_first", 32'(rgb()), 32'h07E0);
        tick_to(pk(41, 510)); check("win_last",  32'(rgb()), 32'h07E0);
        tick_to(pk(41, 511));
        check("win_r_border", 32'(rgb()),  32'h0);
        check("win_r_de",     32'(lcd_de), 32'd1);
        tick_to(pk(41, 526)); check("de_last", 32'(lcd_de), 32'd1);
        tick_to(pk(41, 527)); check("de_end",  32'(lcd_de), 32'd0);

        // Blank forces background inside the window
        tick_to(pk(42, 0));
        blank = 1'b1;
        tick_to(pk(42, 100));
        check("blank_rgb", 32'(rgb()),  32'h0);
        check("blank_de",  32'(lcd_de), 32'd1);
        tick_to(pk(42, 700));
        blank = 1'b0;
        tick_to(pk(43, 100)); check("unblank_rgb", 32'(rgb()), 32'h07E0);

        // Mid-frame asynchronous reset
        tick_to(pk(44, 300));
        check("pre_rst_de",  32'(lcd_de), 32'd1);
        check("pre_rst_rgb", 32'(rgb()),  32'h07E0);
        sys_rst_n = 1'b0;
        #1;
        check_reset_pins("mid_rst");
        check("mid_rst_addr", 32'(u_fb.fb_addr), 32'd0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;

        tick_to(1); check_reset_pins("rel2_1");
        tick_to(2); check_reset_pins("rel2_2");
        tick_to(3);
        check("rel2_fs",    32'(frame_start), 32'd1);
        check("rel2_hsync", 32'(lcd_hsync),   32'd0);
        check("rel2_vsync", 32'(lcd_vsync),   32'd0);
        check("rel2_de",    32'(lcd_de),      32'd0);
        tick_to(4); check("rel2_fs_end", 32'(frame_start), 32'd0);
        tick_to(7); check("rel2_hs_rise", 32'(lcd_hsync), 32'd1);
        tick_to(pk(1, 0)); check("rel2_l1_fs", 32'(frame_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
